// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time between the CPU datapath and a wait-stated
// data memory, with lane formatting, load extension, alignment and timeout errors.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_zero_ext,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            2'b10:   return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic write, input logic [1:0] size,
                                        input logic [1:0] off);
        if (!write) begin
            return 4'b1111;
        end else begin
            case (size)
                2'b00:   return 4'b0001 << off;
                2'b01:   return 4'b0011 << off;
                default: return 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] f_wdata(input logic write, input logic [1:0] size,
                                            input logic [31:0] wdata);
        if (!write) begin
            return 32'h0000_0000;
        end else begin
            case (size)
                2'b00:   return {4{wdata[7:0]}};
                2'b01:   return {2{wdata[15:0]}};
                default: return wdata;
            endcase
        end
    endfunction

    // Byte/half extraction uses the captured offset; word loads pass through.
    function automatic logic [31:0] f_load(input logic [1:0] size, input logic zext,
                                           input logic [1:0] off, input logic [31:0] rdata);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = rdata[{off, 3'b000} +: 8];
        v_half = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return zext ? {24'h00_0000, v_byte} : {{24{v_byte[7]}}, v_byte};
            2'b01:   return zext ? {16'h0000, v_half} : {{16{v_half[15]}}, v_half};
            default: return rdata;
        endcase
    endfunction

    state_t      r_state;
    logic        r_req_ready;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_zext;
    logic [1:0]  r_off;
    logic [15:0] r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    logic [15:0] w_cnt_next;
    logic [31:0] w_load_data;

    assign w_cnt_next  = r_cnt + 16'd1;
    assign w_load_data = f_load(r_size, r_zext, r_off, i_mem_rdata);

    // Request/memory/response sequencing with all outputs registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_zext       <= 1'b0;
            r_off        <= 2'b00;
            r_cnt        <= 16'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write     <= i_req_write;
                        r_size      <= i_req_size;
                        r_zext      <= i_req_zero_ext;
                        r_off       <= i_req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (f_aligned(i_req_size, i_req_addr[1:0])) begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= 16'd0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_req_write;
                            r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            r_mem_be    <= f_be(i_req_write, i_req_size, i_req_addr[1:0]);
                            r_mem_wdata <= f_wdata(i_req_write, i_req_size, i_req_wdata);
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                            r_resp_error <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (i_mem_ack || (w_cnt_next == TO_LIMIT)) begin
                        r_state      <= S_RESP;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= 32'h0000_0000;
                        r_mem_be     <= 4'b0000;
                        r_mem_wdata  <= 32'h0000_0000;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= ~i_mem_ack;
                        r_resp_rdata <= (i_mem_ack && !r_write) ? w_load_data : 32'h0000_0000;
                    end
                    if (!i_mem_ack) begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_resp_error <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_mem_req    <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_resp_error <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_be     = r_mem_be;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_error = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued at request
// time and compared when the unit pulses resp_valid.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_zero_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_wait = 0;
    bit   mem_never = 1'b0;
    int   ack_cnt = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_zero_ext(req_zero_ext),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_error(resp_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: acks after mem_wait wait states unless told never to ack.
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            mem_ack = (!mem_never && ack_cnt == mem_wait);
            ack_cnt++;
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    // Response monitor: pops the scoreboard on each pulse, requires zeros otherwise.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("resp_rdata", resp_rdata, e.rdata);
                check_eq("resp_error", 32'(resp_error), 32'(e.err));
            end
        end else begin
            check_eq("resp_idle_zero", {resp_rdata[31:1], resp_rdata[0] | resp_error}, 32'd0);
        end
    end

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic zx, input logic [31:0] addr, input logic [31:0] wd,
                          input int wait_cyc, input bit never,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_mcyc,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int lat;
        int mcyc;
        exp_t e;
        @(negedge clk);
        mem_wait  = wait_cyc;
        mem_never = never;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_zero_ext = zx;
        req_addr = addr; req_wdata = wd;
        e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        lat  = 1;
        mcyc = 0;
        if (exp_mcyc > 0) begin
            check_eq({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
            check_eq({tag, "_mem_we"}, 32'(mem_we), 32'(wr));
            if (wr) check_eq({tag, "_mem_wdata"}, mem_wdata, exp_wd);
        end
        while (resp_valid !== 1'b1 && lat < 40) begin
            if (mem_req === 1'b1) mcyc++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_mem_cycles"}, 32'(mcyc), 32'(exp_mcyc));
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_zero_ext = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h80FF_1234;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem", {mem_addr[31:6], mem_be, mem_req, mem_we}, 32'd0);
        check_eq("rst_wdata", mem_wdata | mem_addr, 32'd0);
        check_eq("rst_resp", {resp_rdata[31:1], resp_rdata[0] | resp_error | resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Loads: byte/half sign and zero extension, word pass-through.
        do_req("lb_s",  1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 1'b0, 32'hFFFF_FF80, 1'b0, 2, 1, 4'b1111, 32'h0);
        do_req("lb_z",  1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 0, 1'b0, 32'h0000_0080, 1'b0, 2, 1, 4'b1111, 32'h0);
        do_req("lb_0",  1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, 1, 1'b0, 32'h0000_0012, 1'b0, 3, 2, 4'b1111, 32'h0);
        do_req("lh_s",  1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 0, 1'b0, 32'hFFFF_80FF, 1'b0, 2, 1, 4'b1111, 32'h0);
        do_req("lh_z",  1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 0, 1'b0, 32'h0000_80FF, 1'b0, 2, 1, 4'b1111, 32'h0);
        do_req("lh_lo", 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 32'h0000_1234, 1'b0, 2, 1, 4'b1111, 32'h0);
        do_req("lw",    1'b0, 2'b10, 1'b1, 32'h0000_1004, 32'h0, 2, 1'b0, 32'h80FF_1234, 1'b0, 4, 3, 4'b1111, 32'h0);

        // Stores: lane replication and byte enables.
        do_req("sh",    1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 3, 1'b0, 32'h0, 1'b0, 5, 4, 4'b1100, 32'hBEEF_BEEF);
        do_req("sb",    1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 0, 1'b0, 32'h0, 1'b0, 2, 1, 4'b0010, 32'hA5A5_A5A5);
        do_req("sw",    1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, 2, 1, 4'b1111, 32'hDEAD_BEEF);

        // Errors: no memory cycle, response one cycle after accept.
        do_req("e_w",   1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);
        do_req("e_h",   1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h5555_5555, 0, 1'b0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);
        do_req("e_rsv", 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);

        // Timeout, then ack arriving in the last allowed cycle.
        do_req("to",    1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 0, 1'b1, 32'h0, 1'b1, 5, 4, 4'b1111, 32'h0);
        do_req("to_ok", 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 3, 1'b0, 32'h80FF_1234, 1'b0, 5, 4, 4'b1111, 32'h0);

        // Reset in the middle of an access: no response pulse.
        @(negedge clk);
        mem_never = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0000_5000;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("mid_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_never = 1'b0;
        repeat (2) @(negedge clk);
        do_req("after_rst", 1'b0, 2'b00, 1'b1, 32'h0000_1002, 32'h0, 0, 1'b0, 32'h0000_00FF, 1'b0, 2, 1, 4'b1111, 32'h0);

        @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
